// File: rtl/bs_gnrtr_n_rbtr.sv
// rtl/bs_gnrtr_n_rbtr.sv - per-bus round-robin arbiter and packet forwarder; optional BCAST_INCL_SRC_EN
module bs_gnrtr_n_rbtr #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng  [bits-1:0][drvrs-1:0],
    output logic               push   [bits-1:0][drvrs-1:0],
    output logic               pop    [bits-1:0][drvrs-1:0],
    input  logic [pckg_sz-1:0] D_pop  [bits-1:0][drvrs-1:0],
    output logic [pckg_sz-1:0] D_push [bits-1:0][drvrs-1:0]
);
    localparam int IW = $clog2(drvrs);

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t             state;
        logic [IW-1:0]      ptr;
        logic [IW-1:0]      grant;
        logic [IW-1:0]      pick;
        logic [IW-1:0]      idx;
        logic               any_req;
        logic [drvrs-1:0]   req;
        logic [drvrs-1:0]   pop_r;
        logic [drvrs-1:0]   push_r;
        logic [drvrs-1:0]   push_nxt;
        logic [pckg_sz-1:0] pkt;
        logic [pckg_sz-1:0] head;
        logic [7:0]         dest;

        for (genvar i = 0; i < drvrs; i++) begin : g_dev
            assign req[i]       = pndng[b][i];
            assign pop[b][i]    = pop_r[i];
            assign push[b][i]   = push_r[i];
            assign D_push[b][i] = pkt;
        end

        // Scan offsets downward so the requester closest above ptr wins.
        always_comb begin
            any_req = 1'b0;
            pick    = '0;
            idx     = '0;
            for (int k = drvrs - 1; k >= 0; k--) begin
                idx = IW'((int'(ptr) + k) % drvrs);
                if (req[idx]) begin
                    any_req = 1'b1;
                    pick    = idx;
                end
            end
        end

        assign head = D_pop[b][grant];
        assign dest = head[pckg_sz-1 -: 8];

        always_comb begin
            push_nxt = '0;
            if (dest == broadcast) begin
                push_nxt = '1;
`ifndef BCAST_INCL_SRC_EN
                push_nxt[grant] = 1'b0;
`endif
            end else if (int'(dest) < drvrs) begin
                push_nxt[dest[IW-1:0]] = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                ptr    <= '0;
                grant  <= '0;
                pop_r  <= '0;
                push_r <= '0;
                pkt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        push_r <= '0;
                        if (any_req) begin
                            grant       <= pick;
                            pop_r       <= '0;
                            pop_r[pick] <= 1'b1;
                            state       <= POP;
                        end
                    end
                    POP: begin
                        // Head data stays valid through the pop cycle even if pndng drops.
                        pop_r  <= '0;
                        pkt    <= head;
                        push_r <= push_nxt;
                        ptr    <= (grant == IW'(drvrs - 1)) ? '0 : grant + 1'b1;
                        state  <= PUSH;
                    end
                    PUSH: begin
                        push_r <= '0;
                        state  <= IDLE;
                    end
                    default: begin
                        pop_r  <= '0;
                        push_r <= '0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb/tb_bs_gnrtr_n_rbtr.sv - scoreboard bench for bs_gnrtr_n_rbtr, two buses of eight devices
module tb_bs_gnrtr_n_rbtr;
    localparam int NB = 2;
    localparam int ND = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        pndng  [NB-1:0][ND-1:0];
    logic        push   [NB-1:0][ND-1:0];
    logic        pop    [NB-1:0][ND-1:0];
    logic [15:0] D_pop  [NB-1:0][ND-1:0];
    logic [15:0] D_push [NB-1:0][ND-1:0];

    bs_gnrtr_n_rbtr #(.bits(NB), .drvrs(ND), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .push(push),
        .pop(pop), .D_pop(D_pop), .D_push(D_push)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pop_m;
        logic [7:0]  push_m;
        logic [15:0] data;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    ent_t cur [NB];
    bit   pend [NB];
    int   pop_cyc [NB];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pop_vec(int b);
        logic [7:0] v;
        for (int i = 0; i < ND; i++) v[i] = pop[b][i];
        return v;
    endfunction

    function automatic logic [7:0] push_vec(int b);
        logic [7:0] v;
        for (int i = 0; i < ND; i++) v[i] = push[b][i];
        return v;
    endfunction

    function automatic bit any_out();
        bit a = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < ND; i++)
                a = a | push[b][i] | pop[b][i] | (|D_push[b][i]);
        return a;
    endfunction

    function automatic logic [7:0] model_push(int src, logic [15:0] d);
        logic [7:0] dst;
        dst = d[15:8];
        if (dst == 8'hFF) begin
`ifdef BCAST_INCL_SRC_EN
            return 8'hFF;
`else
            return ~(8'b1 << src);
`endif
        end else if (dst < 8'(ND)) begin
            return 8'b1 << dst;
        end
        return 8'h00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop compared against queue head, push/D_push one cycle later.
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            bit         handled;
            logic [7:0] pv;
            ent_t       e;
            handled = pend[b];
            if (pend[b]) begin
                chk($sformatf("push_b%0d", b), push_vec(b), cur[b].push_m);
                for (int i = 0; i < ND; i++)
                    chk($sformatf("dpush_b%0d_d%0d", b, i), D_push[b][i], cur[b].data);
                pend[b] = 1'b0;
            end
            pv = pop_vec(b);
            if (pv != 8'h00) begin
                if ((b == 0 ? q0.size() : q1.size()) == 0) begin
                    chk($sformatf("unexpected_pop_b%0d", b), pv, 0);
                end else begin
                    e = (b == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("pop_b%0d", b), pv, e.pop_m);
                    cur[b]     = e;
                    pend[b]    = 1'b1;
                    pop_cyc[b] = cyc;
                end
            end else if (!handled && push_vec(b) != 8'h00) begin
                chk($sformatf("unexpected_push_b%0d", b), push_vec(b), 0);
            end
        end
    end

    task automatic expect_txn(int b, int src, logic [15:0] data, bit killed);
        ent_t e;
        e.pop_m  = 8'b1 << src;
        e.push_m = killed ? 8'h00 : model_push(src, data);
        e.data   = killed ? 16'h0000 : data;
        if (b == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic req(int b, int d, logic [15:0] data);
        D_pop[b][d] = data;
        pndng[b][d] = 1'b1;
    endtask

    task automatic clear_pndng();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < ND; i++) pndng[b][i] = 1'b0;
    endtask

    task automatic wait_q(int n, int budget);
        for (int k = 0; k <= budget; k++) begin
            @(negedge clk); #1;
            if (q0.size() + q1.size() <= n) return;
        end
        chk("pop_timeout", q0.size() + q1.size(), n);
        q0.delete();
        q1.delete();
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
        chk("scoreboard_drained", {30'd0, pend[1] | pend[0], (q0.size() + q1.size()) != 0}, 0);
    endtask

    initial begin
        int t0;
        reset = 1'b0;
        for (int b = 0; b < NB; b++) begin
            pend[b] = 1'b0;
            for (int i = 0; i < ND; i++) begin
                pndng[b][i] = 1'b1;
                D_pop[b][i] = 16'h0000;
            end
        end

        // Reset held with every source pending: nothing may move.
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset_outputs", any_out(), 0);
        end
        expect_txn(0, 0, 16'h0000, 1'b0);
        expect_txn(1, 0, 16'h0000, 1'b0);
        reset = 1'b1;
        wait_q(0, 3);
        clear_pndng();
        settle();

        // Unicast: exact latency of pop then push.
        expect_txn(0, 0, 16'h03AB, 1'b0);
        req(0, 0, 16'h03AB);
        @(posedge clk);
        @(negedge clk); #1;
        chk("latency_pop", pop_vec(0), 8'h01);
        clear_pndng();
        @(negedge clk); #1;
        chk("latency_push", push_vec(0), 8'h08);
        chk("latency_dpush3", D_push[0][3], 16'h03AB);
        settle();

        // Broadcast from device 2.
        expect_txn(0, 2, 16'hFF55, 1'b0);
        req(0, 2, 16'hFF55);
        wait_q(0, 4);
        clear_pndng();
        settle();

        // Out-of-range destination dropped; next grant exactly 3 cycles later.
        expect_txn(0, 4, 16'h0200, 1'b0);
        expect_txn(0, 1, 16'h0A00, 1'b0);
        req(0, 4, 16'h0200);
        req(0, 1, 16'h0A00);
        wait_q(1, 4);
        t0 = pop_cyc[0];
        pndng[0][4] = 1'b0;
        wait_q(0, 5);
        clear_pndng();
        chk("drop_then_idle_gap", pop_cyc[0] - t0, 3);
        settle();

        // Continuous requests from 0, 3, 5 after pointer reset.
        reset = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            expect_txn(0, 0, 16'h0111, 1'b0);
            expect_txn(0, 3, 16'hFF33, 1'b0);
            expect_txn(0, 5, 16'h0755, 1'b0);
        end
        req(0, 0, 16'h0111);
        req(0, 3, 16'hFF33);
        req(0, 5, 16'h0755);
        wait_q(1, 20);
        t0 = pop_cyc[0];
        wait_q(0, 5);
        clear_pndng();
        chk("rr_throughput", pop_cyc[0] - t0, 3);
        settle();

        // Two buses in parallel, then reset during POP kills the push.
        expect_txn(0, 1, 16'h0512, 1'b0);
        expect_txn(1, 6, 16'h0234, 1'b0);
        req(0, 1, 16'h0512);
        req(1, 6, 16'h0234);
        wait_q(0, 4);
        clear_pndng();
        chk("bus_parallel_pop", pop_cyc[0] - pop_cyc[1], 0);
        settle();

        expect_txn(0, 4, 16'h0100, 1'b1);
        expect_txn(1, 3, 16'hFF77, 1'b1);
        req(0, 4, 16'h0100);
        req(1, 3, 16'hFF77);
        wait_q(0, 4);
        reset = 1'b0;
        clear_pndng();
        @(negedge clk); #1;
        chk("reset_mid_outputs", any_out(), 0);
        reset = 1'b1;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
